veer_mpc_dbg_hub: RTL and testbench

Debug hub for multi-hart VeeR subsystems, placed between the single DMI register port from the JTAG/DMI transport and NUM_HARTS core wrappers. It forwards DMI register accesses to the hart chosen by a local hart-select register. It also owns a small local register window that runs masked, timed MPC halt/run handshakes across several harts at once. Unlike the single-core wrapper, which exposes one DMI port and raw MPC pins, this block generalises both to N harts and adds sequencing, timeout and per-hart halted status.

---
 rtl/veer_mpc_dbg_hub.sv | 105 ++++++++++
 tb/tb_veer_mpc_dbg_hub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/veer_mpc_dbg_hub.sv
// veer_mpc_dbg_hub: DMI fan-out to N harts plus masked, timed MPC halt/run sequencer
module veer_mpc_dbg_hub #(
  parameter int NUM_HARTS = 2,
  parameter int TIMEOUT_W = 8,
  parameter logic [6:0] LOCAL_BASE = 7'h40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dmi_reg_en,
  input  logic [6:0]                dmi_reg_addr,
  input  logic                      dmi_reg_wr_en,
  input  logic [31:0]               dmi_reg_wdata,
  output logic [31:0]               dmi_reg_rdata,
  output logic [NUM_HARTS-1:0]      h_dmi_reg_en,
  output logic [6:0]                h_dmi_reg_addr,
  output logic                      h_dmi_reg_wr_en,
  output logic [31:0]               h_dmi_reg_wdata,
  input  logic [32*NUM_HARTS-1:0]   h_dmi_reg_rdata,
  output logic [NUM_HARTS-1:0]      mpc_debug_halt_req,
  output logic [NUM_HARTS-1:0]      mpc_debug_run_req,
  input  logic [NUM_HARTS-1:0]      mpc_debug_halt_ack,
  input  logic [NUM_HARTS-1:0]      mpc_debug_run_ack
);
  localparam int HSW = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1;
  typedef enum logic [1:0] {IDLE, HALT_REQ, RUN_REQ} state_t;
  state_t r_state, w_state_nxt;
  logic [HSW-1:0] r_hartsel, r_src;
  logic r_fwd, r_timeout, r_illegal, r_dir;
  logic [31:0] r_rdata, w_ctrl, w_lrd;
  logic [NUM_HARTS-1:0] r_mask, r_pend, r_halted, w_ack, w_pend_nxt;
  logic [TIMEOUT_W-1:0] r_tmo, r_tlim, r_cnt;
  logic [6:0] w_off;
  logic w_local, w_wr, w_rd, w_ctrl_wr, w_halt_go, w_run_go, w_go, w_busy;
  logic w_go_bad, w_start, w_sel_bad, w_clr, w_done, w_fire;
  assign w_off = dmi_reg_addr - LOCAL_BASE;
  assign w_local = w_off[6:2] == 5'd0;
  assign w_wr = dmi_reg_en && dmi_reg_wr_en && w_local;
  assign w_rd = dmi_reg_en && !dmi_reg_wr_en;
  assign w_ctrl_wr = w_wr && w_off[1:0] == 2'd1;
  assign w_halt_go = w_ctrl_wr && dmi_reg_wdata[0];
  assign w_run_go = w_ctrl_wr && dmi_reg_wdata[1];
  assign w_clr = w_ctrl_wr && dmi_reg_wdata[2];
  assign w_go = w_halt_go || w_run_go;
  assign w_busy = r_state != IDLE;
  assign w_go_bad = w_go && ((w_halt_go && w_run_go) || w_busy || r_mask == '0);
  assign w_start = w_go && !w_go_bad;
  assign w_sel_bad = w_wr && w_off[1:0] == 2'd0 && dmi_reg_wdata >= 32'(NUM_HARTS);
  assign w_ack = r_state == HALT_REQ ? mpc_debug_halt_ack : mpc_debug_run_ack;
  assign w_pend_nxt = r_pend & ~w_ack;
  assign w_done = w_busy && w_pend_nxt == '0;
  assign w_fire = w_busy && !w_done && r_tlim != '0 && r_cnt == r_tlim;
  assign w_ctrl = (32'(r_halted) << 16) | {28'd0, r_dir, r_illegal, r_timeout, w_busy};
  assign w_lrd = w_off[1:0] == 2'd0 ? 32'(r_hartsel) :
                 w_off[1:0] == 2'd1 ? w_ctrl :
                 w_off[1:0] == 2'd2 ? 32'(r_mask) : 32'(r_tmo);
  assign h_dmi_reg_en = dmi_reg_en && !w_local ? NUM_HARTS'(1) << r_hartsel : '0;
  assign h_dmi_reg_addr = dmi_reg_addr;
  assign h_dmi_reg_wr_en = dmi_reg_wr_en;
  assign h_dmi_reg_wdata = dmi_reg_wdata;
  assign dmi_reg_rdata = r_fwd ? h_dmi_reg_rdata[32*r_src +: 32] : r_rdata;
  assign mpc_debug_halt_req = r_state == HALT_REQ ? r_pend : '0;
  assign mpc_debug_run_req = r_state == RUN_REQ ? r_pend : '0;
  always_comb
    w_state_nxt = w_start ? (w_halt_go ? HALT_REQ : RUN_REQ) : (w_done || w_fire) ? IDLE : r_state;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hartsel <= '0;
      r_src <= '0;
      r_fwd <= 1'b0;
      r_rdata <= '0;
      r_mask <= '1;
      r_tmo <= '1;
      r_tlim <= '0;
      r_cnt <= '0;
      r_pend <= '0;
      r_halted <= '0;
      r_timeout <= 1'b0;
      r_illegal <= 1'b0;
      r_dir <= 1'b0;
    end else begin
      if (w_wr && w_off[1:0] == 2'd0 && !w_sel_bad) r_hartsel <= dmi_reg_wdata[HSW-1:0];
      if (w_wr && w_off[1:0] == 2'd2) r_mask <= dmi_reg_wdata[NUM_HARTS-1:0];
      if (w_wr && w_off[1:0] == 2'd3) r_tmo <= dmi_reg_wdata[TIMEOUT_W-1:0];
      r_illegal <= (r_illegal && !w_clr) || w_sel_bad || w_go_bad;
      r_timeout <= (r_timeout && !w_clr) || w_fire;
      r_halted <= (r_halted & ~mpc_debug_run_ack) | mpc_debug_halt_ack;
      if (w_start) begin
        r_pend <= r_mask;
        r_cnt <= '0;
        r_tlim <= r_tmo;
        r_dir <= w_halt_go;
      end else begin
        r_pend <= w_fire ? '0 : w_pend_nxt;
        r_cnt <= w_busy && r_cnt != '1 ? r_cnt + 1'b1 : r_cnt;
      end
      if (w_rd) begin
        r_fwd <= !w_local;
        r_src <= r_hartsel;
        if (w_local) r_rdata <= w_lrd;
      end
    end
  end
endmodule

// File: tb/tb_veer_mpc_dbg_hub.sv
// tb_veer_mpc_dbg_hub: vector table, handshake sequences and randomized model check of the debug hub
module tb_veer_mpc_dbg_hub;
  localparam int N = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic dmi_reg_en = 1'b0, dmi_reg_wr_en = 1'b0;
  logic [6:0] dmi_reg_addr = '0;
  logic [31:0] dmi_reg_wdata = '0, dmi_reg_rdata, h_dmi_reg_wdata;
  logic [N-1:0] h_dmi_reg_en, mpc_debug_halt_req, mpc_debug_run_req;
  logic [N-1:0] mpc_debug_halt_ack = '0, mpc_debug_run_ack = '0;
  logic [6:0] h_dmi_reg_addr;
  logic h_dmi_reg_wr_en;
  logic [32*N-1:0] h_dmi_reg_rdata = '0;
  int n_pass = 0, n_chk = 0;
  veer_mpc_dbg_hub #(.NUM_HARTS(N), .TIMEOUT_W(8), .LOCAL_BASE(7'h40)) dut (
    .clk(clk), .rst(rst),
    .dmi_reg_en(dmi_reg_en), .dmi_reg_addr(dmi_reg_addr), .dmi_reg_wr_en(dmi_reg_wr_en),
    .dmi_reg_wdata(dmi_reg_wdata), .dmi_reg_rdata(dmi_reg_rdata),
    .h_dmi_reg_en(h_dmi_reg_en), .h_dmi_reg_addr(h_dmi_reg_addr), .h_dmi_reg_wr_en(h_dmi_reg_wr_en),
    .h_dmi_reg_wdata(h_dmi_reg_wdata), .h_dmi_reg_rdata(h_dmi_reg_rdata),
    .mpc_debug_halt_req(mpc_debug_halt_req), .mpc_debug_run_req(mpc_debug_run_req),
    .mpc_debug_halt_ack(mpc_debug_halt_ack), .mpc_debug_run_ack(mpc_debug_run_ack)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic wr;
    logic [6:0] addr;
    logic [31:0] wdata;
    logic [63:0] hrd;
    logic [1:0] en;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[15];
  int m_hsel, m_tmo, m_cnt, m_lim, m_src;
  logic [N-1:0] m_mask, m_pend, m_halted;
  logic m_busy, m_dir, m_to, m_ill, m_fwd;
  logic [31:0] m_rd;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    dmi_reg_en = 1'b1; dmi_reg_wr_en = 1'b1; dmi_reg_addr = a; dmi_reg_wdata = d;
    step();
    dmi_reg_en = 1'b0; dmi_reg_wr_en = 1'b0;
  endtask
  task automatic rd_chk(input string nm, input logic [6:0] a, input logic [31:0] exp);
    dmi_reg_en = 1'b1; dmi_reg_wr_en = 1'b0; dmi_reg_addr = a;
    step();
    dmi_reg_en = 1'b0;
    chk(nm, dmi_reg_rdata, exp);
  endtask
  function automatic vec_t mk(logic w, logic [6:0] a, logic [31:0] d, logic [63:0] h, logic [1:0] e, logic [31:0] r);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = d; v.hrd = h; v.en = e; v.rd = r;
    return v;
  endfunction
  function automatic logic [31:0] mreg(int off);
    logic [31:0] c;
    c = (32'(m_halted) << 16) | {28'd0, m_dir, m_ill, m_to, m_busy};
    return off == 0 ? 32'(m_hsel) : off == 1 ? c : off == 2 ? 32'(m_mask) : 32'(m_tmo);
  endfunction
  initial begin
    logic [63:0] h0, h1;
    h0 = 64'hCAFE0001_12345678;
    h1 = 64'h0BAD0BAD_A5A50000;
    tbl[0]  = mk(0, 7'h40, 0, h0, 2'b00, 32'h0);
    tbl[1]  = mk(0, 7'h41, 0, h0, 2'b00, 32'h0);
    tbl[2]  = mk(0, 7'h42, 0, h0, 2'b00, 32'h3);
    tbl[3]  = mk(0, 7'h43, 0, h0, 2'b00, 32'hFF);
    tbl[4]  = mk(1, 7'h40, 1, h0, 2'b00, 32'hFF);
    tbl[5]  = mk(0, 7'h04, 0, h0, 2'b10, 32'hCAFE0001);
    tbl[6]  = mk(1, 7'h40, 2, h0, 2'b00, 32'hCAFE0001);
    tbl[7]  = mk(0, 7'h41, 0, h0, 2'b00, 32'h4);
    tbl[8]  = mk(0, 7'h40, 0, h0, 2'b00, 32'h1);
    tbl[9]  = mk(1, 7'h41, 4, h0, 2'b00, 32'h1);
    tbl[10] = mk(0, 7'h41, 0, h0, 2'b00, 32'h0);
    tbl[11] = mk(1, 7'h40, 0, h0, 2'b00, 32'h0);
    tbl[12] = mk(0, 7'h3F, 0, h0, 2'b01, 32'h12345678);
    tbl[13] = mk(0, 7'h44, 0, h1, 2'b01, 32'hA5A50000);
    tbl[14] = mk(1, 7'h05, 32'hDEAD, h1, 2'b01, 32'hA5A50000);
    repeat (3) step();
    rst = 1'b0;
    chk("reset_rdata", dmi_reg_rdata, 0);
    chk("reset_halt_req", 32'(mpc_debug_halt_req), 0);
    chk("reset_run_req", 32'(mpc_debug_run_req), 0);
    foreach (tbl[i]) begin
      dmi_reg_en = 1'b1; dmi_reg_wr_en = tbl[i].wr; dmi_reg_addr = tbl[i].addr;
      dmi_reg_wdata = tbl[i].wdata; h_dmi_reg_rdata = tbl[i].hrd;
      #1;
      chk($sformatf("tbl[%0d].h_en", i), 32'(h_dmi_reg_en), 32'(tbl[i].en));
      chk($sformatf("tbl[%0d].h_addr", i), 32'(h_dmi_reg_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl[%0d].h_wdata", i), h_dmi_reg_wdata, tbl[i].wdata);
      chk($sformatf("tbl[%0d].h_wr", i), 32'(h_dmi_reg_wr_en), 32'(tbl[i].wr));
      step();
      dmi_reg_en = 1'b0; dmi_reg_wr_en = 1'b0;
      chk($sformatf("tbl[%0d].rdata", i), dmi_reg_rdata, tbl[i].rd);
    end
    wr(7'h41, 1);
    chk("halt_t1", 32'(mpc_debug_halt_req), 3);
    step();
    chk("halt_t2", 32'(mpc_debug_halt_req), 3);
    mpc_debug_halt_ack = 2'b01;
    step();
    mpc_debug_halt_ack = 2'b00;
    chk("halt_t3", 32'(mpc_debug_halt_req), 2);
    rd_chk("halt_ctrl_busy", 7'h41, 32'h0001_0009);
    chk("halt_t4", 32'(mpc_debug_halt_req), 2);
    chk("halt_t4_run", 32'(mpc_debug_run_req), 0);
    step();
    chk("halt_t5", 32'(mpc_debug_halt_req), 2);
    mpc_debug_halt_ack = 2'b10;
    step();
    mpc_debug_halt_ack = 2'b00;
    chk("halt_t6", 32'(mpc_debug_halt_req), 0);
    rd_chk("halt_ctrl_done", 7'h41, 32'h0003_0008);
    wr(7'h43, 4);
    wr(7'h41, 2);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("tmo_run_t%0d", k), 32'(mpc_debug_run_req), k <= 5 ? 3 : 0);
      if (k < 6) step();
    end
    rd_chk("tmo_ctrl", 7'h41, 32'h0003_0002);
    wr(7'h41, 4);
    rd_chk("tmo_cleared", 7'h41, 32'h0003_0000);
    wr(7'h41, 3);
    chk("both_go_halt", 32'(mpc_debug_halt_req), 0);
    chk("both_go_run", 32'(mpc_debug_run_req), 0);
    rd_chk("both_go_ctrl", 7'h41, 32'h0003_0004);
    wr(7'h41, 4);
    wr(7'h43, 0);
    wr(7'h41, 1);
    chk("busy_halt_t1", 32'(mpc_debug_halt_req), 3);
    wr(7'h41, 1);
    chk("busy_go_halt", 32'(mpc_debug_halt_req), 3);
    rd_chk("busy_go_ctrl", 7'h41, 32'h0003_000D);
    rst = 1'b1;
    step();
    chk("rst_halt_req", 32'(mpc_debug_halt_req), 0);
    chk("rst_rdata", dmi_reg_rdata, 0);
    rst = 1'b0;
    rd_chk("rst_hartsel", 7'h40, 0);
    rd_chk("rst_ctrl", 7'h41, 0);
    rd_chk("rst_mask", 7'h42, 3);
    rd_chk("rst_tmo", 7'h43, 32'hFF);
    wr(7'h42, 0);
    wr(7'h41, 1);
    chk("mask0_halt", 32'(mpc_debug_halt_req), 0);
    rd_chk("mask0_ctrl", 7'h41, 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_hsel = 0; m_tmo = 255; m_cnt = 0; m_lim = 0; m_src = 0;
    m_mask = '1; m_pend = '0; m_halted = '0;
    m_busy = 0; m_dir = 0; m_to = 0; m_ill = 0; m_fwd = 0; m_rd = 0;
    for (int c = 0; c < 3000; c++) begin
      logic lc, ob;
      logic [N-1:0] omask, mack;
      int off, otmo, r;
      dmi_reg_en = $urandom_range(0, 2) == 0;
      dmi_reg_wr_en = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 5);
      dmi_reg_addr = r < 4 ? 7'(7'h40 + r) : 7'($urandom_range(0, 127));
      dmi_reg_wdata = $urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 7);
      mpc_debug_halt_ack = N'($urandom & $urandom & $urandom);
      mpc_debug_run_ack = N'($urandom & $urandom & $urandom) & ~mpc_debug_halt_ack;
      h_dmi_reg_rdata = {$urandom, $urandom};
      #1;
      lc = dmi_reg_addr >= 7'h40 && dmi_reg_addr <= 7'h43;
      off = int'(dmi_reg_addr) - 64;
      chk("rnd_h_en", 32'(h_dmi_reg_en), dmi_reg_en && !lc ? 32'(1 << m_hsel) : 0);
      chk("rnd_halt_req", 32'(mpc_debug_halt_req), m_busy && m_dir ? 32'(m_pend) : 0);
      chk("rnd_run_req", 32'(mpc_debug_run_req), m_busy && !m_dir ? 32'(m_pend) : 0);
      chk("rnd_rdata", dmi_reg_rdata, m_fwd ? h_dmi_reg_rdata[32*m_src +: 32] : m_rd);
      if (dmi_reg_en && !dmi_reg_wr_en) begin
        if (lc) m_rd = mreg(off);
        m_fwd = !lc;
        m_src = m_hsel;
      end
      ob = m_busy; omask = m_mask; otmo = m_tmo;
      if (dmi_reg_en && dmi_reg_wr_en && lc && off == 1 && dmi_reg_wdata[2]) begin
        m_to = 0; m_ill = 0;
      end
      for (int i = 0; i < N; i++)
        m_halted[i] = mpc_debug_halt_ack[i] ? 1'b1 : mpc_debug_run_ack[i] ? 1'b0 : m_halted[i];
      if (ob) begin
        mack = m_dir ? mpc_debug_halt_ack : mpc_debug_run_ack;
        for (int i = 0; i < N; i++) if (mack[i]) m_pend[i] = 1'b0;
        if (m_pend == '0) m_busy = 0;
        else if (m_lim != 0 && m_cnt == m_lim) begin
          m_to = 1; m_pend = '0; m_busy = 0;
        end else if (m_cnt < 255) m_cnt++;
      end
      if (dmi_reg_en && dmi_reg_wr_en && lc) begin
        if (off == 0) begin
          if (dmi_reg_wdata < N) m_hsel = int'(dmi_reg_wdata);
          else m_ill = 1;
        end else if (off == 1 && (dmi_reg_wdata[0] || dmi_reg_wdata[1])) begin
          if ((dmi_reg_wdata[0] && dmi_reg_wdata[1]) || ob || omask == '0) m_ill = 1;
          else begin
            m_busy = 1; m_dir = dmi_reg_wdata[0]; m_pend = omask; m_cnt = 0; m_lim = otmo;
          end
        end else if (off == 2) m_mask = dmi_reg_wdata[N-1:0];
        else if (off == 3) m_tmo = int'(dmi_reg_wdata[7:0]);
      end
      @(posedge clk);
      #1;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
